// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard score-update controller.
package placar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    COMPUTE,
    WRITE,
    ACK
  } state_t;

  localparam logic HOME = 1'b0;
  localparam logic AWAY = 1'b1;

  localparam int MAX_SCORE_DEF = 99;

endpackage

// File: rtl/somador_subitrator7bts.sv
// 7-bit adder/subtractor: S = A + B (i_cin=0) or A - B (i_cin=1, two's complement).
// For subtraction o_cout = 1 means no borrow (A >= B).
module somador_subitrator7bts (
  input  logic [6:0] i_a,
  input  logic [6:0] i_b,
  input  logic       i_cin,
  output logic [6:0] o_s,
  output logic       o_cout
);

  logic [6:0] w_b_eff;

  assign w_b_eff       = i_b ^ {7{i_cin}};
  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, w_b_eff} + {7'b0, i_cin};

endmodule

// File: rtl/controlador_placar.sv
// Score-update controller: round-robin arbitration of home/away point requests
// over one shared adder/subtractor, with saturation at MAX_SCORE and clamp at 0.
module controlador_placar
  import placar_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_home,
  input  logic       req_away,
  input  logic [1:0] pts_home,
  input  logic [1:0] pts_away,
  input  logic       sub_home,
  input  logic       sub_away,
  input  logic       clr,
  output logic [6:0] score_home,
  output logic [6:0] score_away,
  output logic       ack_home,
  output logic       ack_away,
  output logic       busy,
  output logic       sat
);

  localparam logic [6:0] MAX7 = 7'(MAX_SCORE);

  state_t     r_state;
  state_t     w_next;
  logic       r_last_grant;
  logic       r_grant_id;
  logic [6:0] r_op_a;
  logic [1:0] r_op_b;
  logic       r_op_sub;
  logic [6:0] r_res;
  logic       r_cout;
  logic       r_sat;
  logic [6:0] r_score_home;
  logic [6:0] r_score_away;

  logic       w_pick;
  logic [6:0] w_sum;
  logic       w_cout;
  logic [6:0] w_wr_val;
  logic       w_wr_sat;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_home || req_away) w_next = GRANT;
      GRANT:   w_next = COMPUTE;
      COMPUTE: w_next = WRITE;
      WRITE:   w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clr) w_next = IDLE;
  end

  // Round-robin: on a tie the team not served last wins.
  always_comb begin
    w_pick = ~r_last_grant;
    if (req_home && !req_away)      w_pick = HOME;
    else if (req_away && !req_home) w_pick = AWAY;
  end

  somador_subitrator7bts u_somador (
    .i_a    (r_op_a),
    .i_b    ({5'b0, r_op_b}),
    .i_cin  (r_op_sub),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  // A borrow on subtract clamps to 0; an add above MAX_SCORE saturates.
  always_comb begin
    w_wr_val = r_res;
    w_wr_sat = 1'b0;
    if (r_op_sub) begin
      if (!r_cout) begin
        w_wr_val = 7'd0;
        w_wr_sat = 1'b1;
      end
    end else if (r_res > MAX7) begin
      w_wr_val = MAX7;
      w_wr_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= AWAY;
      r_grant_id   <= HOME;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_sub     <= 1'b0;
      r_res        <= '0;
      r_cout       <= 1'b0;
      r_sat        <= 1'b0;
      r_score_home <= '0;
      r_score_away <= '0;
    end else if (clr) begin
      r_score_home <= '0;
      r_score_away <= '0;
      r_sat        <= 1'b0;
    end else begin
      unique case (r_state)
        GRANT: begin
          r_grant_id <= w_pick;
          r_op_a     <= (w_pick == HOME) ? r_score_home : r_score_away;
          r_op_b     <= (w_pick == HOME) ? pts_home : pts_away;
          r_op_sub   <= (w_pick == HOME) ? sub_home : sub_away;
        end
        COMPUTE: begin
          r_res  <= w_sum;
          r_cout <= w_cout;
        end
        WRITE: begin
          r_sat <= w_wr_sat;
          if (r_grant_id == HOME) r_score_home <= w_wr_val;
          else                    r_score_away <= w_wr_val;
        end
        ACK:     r_last_grant <= r_grant_id;
        default: ;
      endcase
    end
  end

  assign score_home = r_score_home;
  assign score_away = r_score_away;
  assign busy       = (r_state != IDLE);
  assign ack_home   = (r_state == ACK) && (r_grant_id == HOME);
  assign ack_away   = (r_state == ACK) && (r_grant_id == AWAY);
  assign sat        = (r_state == ACK) && r_sat;

endmodule
